// File: rtl/keypad_calc_pkg.sv
// rtl/keypad_calc_pkg.sv - shared types and helpers for the keypad calculator
// Contents: calc_state_t, key_code_t, scan_state_t, seg7(), bcd_digit_add()
package keypad_calc_pkg;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, SHOW_RES} calc_state_t;

  typedef enum logic [3:0] {
    K0 = 4'd0, K1 = 4'd1, K2 = 4'd2, K3 = 4'd3, K4 = 4'd4,
    K5 = 4'd5, K6 = 4'd6, K7 = 4'd7, K8 = 4'd8, K9 = 4'd9,
    K_ADD = 4'd10, K_CE = 4'd11, K_AC = 4'd12, K_EQ = 4'd13,
    K_NONE = 4'd15
  } key_code_t;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes decode to blank.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // One BCD digit: returns {carry_out, sum_digit}. Max raw sum is 19,
  // which after the +6 correction still fits in 5 bits.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y,
                                               input logic cin);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (s > 5'd9) s = s + 5'd6;
    return s;
  endfunction

endpackage

// File: rtl/keypad_calc_if.sv
// rtl/keypad_calc_if.sv - keypad and display pins of the calculator
// filas_raw: rows in (active-low), columnas: column drive, d: segments,
// a: digit enables, led: status. slave = calculator side, master = board side.
interface keypad_calc_if #(parameter int DIGITS = 4);
  logic [3:0]        filas_raw;
  logic [3:0]        columnas;
  logic [6:0]        d;
  logic [DIGITS-1:0] a;
  logic [3:0]        led;

  modport slave  (input filas_raw, output columnas, d, a, led);
  modport master (output filas_raw, input columnas, d, a, led);
endinterface

// File: rtl/keypad_calc_scanner.sv
// rtl/keypad_calc_scanner.sv - row sync, column scan and debounce of a 4x4 keypad
// In: clk, reset, filas_raw. Out: columnas, key_valid (1-cycle pulse),
// key_code (valid with key_valid), key_held (debounced key down).
module keypad_scanner
  import keypad_calc_pkg::*;
#(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] filas_raw,
  output logic [3:0] columnas,
  output logic       key_valid,
  output key_code_t  key_code,
  output logic       key_held
);
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  logic [3:0]  sync1_q, sync2_q;
  scan_state_t state_q, state_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]  col_q, col_d, row_q, row_d, low_row;
  logic        key_valid_q, key_valid_d;
  key_code_t   key_code_q, key_code_d;
  logic        any_low;

  function automatic key_code_t keymap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return K1;    4'h1: return K2;    4'h2: return K3;  4'h3: return K_ADD;
      4'h4: return K4;    4'h5: return K5;    4'h6: return K6;  4'h7: return K_CE;
      4'h8: return K7;    4'h9: return K8;    4'hA: return K9;
      4'hC: return K_AC;  4'hD: return K0;    4'hE: return K_EQ;
      default: return K_NONE;
    endcase
  endfunction

  assign any_low = ~&sync2_q;

  // Lowest-index low row wins: scan downwards so the last hit is the lowest.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) if (!sync2_q[i]) low_row = 2'(i);
  end

  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    case (state_q)
      SCAN: begin
        // Rows only reflect the current column once the 2-flop synchroniser
        // has refilled after a column change, so earlier samples are ignored.
        if (any_low && scan_cnt_q >= SW'(2)) begin
          state_d    = DEBOUNCE;
          row_d      = low_row;
          deb_cnt_d  = DW'(1);
          scan_cnt_d = '0;
        end else if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (!any_low) begin
          state_d = SCAN;
        end else if (low_row != row_q) begin
          row_d     = low_row;
          deb_cnt_d = DW'(1);
        end else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          key_valid_d = 1'b1;
          key_code_d  = keymap(row_q, col_q);
          state_d     = HELD;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!any_low) begin
          state_d   = RELEASE;
          deb_cnt_d = '0;
        end
      end
      default: begin
        if (any_low) deb_cnt_d = '0;
        else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) state_d = SCAN;
        else deb_cnt_d = deb_cnt_q + DW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      state_q     <= SCAN;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= K_NONE;
    end else begin
      sync1_q     <= filas_raw;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign columnas  = ~(4'b0001 << col_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = (state_q == HELD);
endmodule

// File: rtl/keypad_calc_top.sv
// rtl/keypad_calc_top.sv - keypad BCD adding calculator with muxed 7-seg display
// In: clk, reset, io.filas_raw. Out: io.columnas, io.d (segments),
// io.a (digit enables), io.led = {key_held, SHOW_RES, ENTER_B, overflow}.
module keypad_calc_top
  import keypad_calc_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int BLANK_LZ        = 1
) (
  input  logic          clk,
  input  logic          reset,
  keypad_calc_if.slave  io
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam int RW = $clog2(REFRESH_CYCLES);

  logic        key_valid, key_held;
  key_code_t   key_code;
  logic [3:0]  kc;
  logic        is_digit;

  calc_state_t   state_q, state_d;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic          ovf_q, ovf_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;

  logic [W-1:0]  sum, src;
  logic          carry;
  logic [4:0]    t;
  logic [3:0]    digit;
  logic          blank;

  keypad_scanner #(.SCAN_CYCLES(SCAN_CYCLES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .filas_raw (io.filas_raw),
    .columnas  (io.columnas),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  // Ripple BCD adder; the final carry is the overflow out of the top digit.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    t     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      t              = bcd_digit_add(opa_q[i*4 +: 4], opb_q[i*4 +: 4], carry);
      sum[i*4 +: 4]  = t[3:0];
      carry          = t[4];
    end
  end

  assign kc       = key_code;
  assign is_digit = (kc <= 4'd9);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    if (key_valid) begin
      if (is_digit) begin
        case (state_q)
          ENTER_A: if (opa_q[W-1 -: 4] == 4'd0) opa_d = {opa_q[W-5:0], kc};
          ENTER_B: if (opb_q[W-1 -: 4] == 4'd0) opb_d = {opb_q[W-5:0], kc};
          default: begin
            opa_d   = {{(W-4){1'b0}}, kc};
            opb_d   = '0;
            ovf_d   = 1'b0;
            state_d = ENTER_A;
          end
        endcase
      end else begin
        case (key_code)
          K_ADD: begin
            opb_d = '0;
            case (state_q)
              ENTER_A: state_d = ENTER_B;
              ENTER_B: begin
                opa_d = sum;
                ovf_d = ovf_q | carry;
              end
              default: begin
                opa_d   = res_q;
                state_d = ENTER_B;
              end
            endcase
          end
          K_CE: begin
            case (state_q)
              ENTER_A: opa_d = '0;
              ENTER_B: opb_d = '0;
              default: res_d = '0;
            endcase
          end
          K_AC: begin
            opa_d   = '0;
            opb_d   = '0;
            res_d   = '0;
            ovf_d   = 1'b0;
            state_d = ENTER_A;
          end
          K_EQ: begin
            if (state_q == ENTER_B) begin
              res_d   = sum;
              ovf_d   = ovf_q | carry;
              state_d = SHOW_RES;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q + RW'(1);
    idx_d     = idx_q;
    if (ref_cnt_q == RW'(REFRESH_CYCLES - 1)) begin
      ref_cnt_d = '0;
      idx_d     = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ENTER_A;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      idx_q     <= '0;
      ref_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      idx_q     <= idx_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  // Display path is combinational from registered state so a key's effect
  // shows on the enabled digit in the same cycle the register updates.
  always_comb begin
    case (state_q)
      ENTER_A: src = opa_q;
      ENTER_B: src = opb_q;
      default: src = res_q;
    endcase
    digit = src[idx_q*4 +: 4];
    // Blank when this digit and every higher one are zero; digit 0 always shows.
    blank = (BLANK_LZ != 0) && (idx_q != '0) && ((src >> {idx_q, 2'b00}) == '0);
  end

  assign io.d   = blank ? 7'h7F : seg7(digit);
  assign io.a   = ~(DIGITS'(1) << idx_q);
  assign io.led = {key_held, state_q == SHOW_RES, state_q == ENTER_B, ovf_q};
endmodule

// File: tb/tb_keypad_calc_top.sv
// tb/tb_keypad_calc_top.sv - scoreboard bench for keypad_calc_top
module tb_keypad_calc_top;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_calc_if #(.DIGITS(4)) io();

  keypad_calc_top #(
    .DIGITS(4), .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8), .REFRESH_CYCLES(4), .BLANK_LZ(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  // Keypad model: a pressed key pulls its row low only while its column is driven.
  logic       key_down = 1'b0;
  int         key_r = 0, key_c = 0;
  logic [3:0] rows;
  always_comb begin
    rows = 4'hF;
    if (key_down && io.columnas[key_c] == 1'b0) rows[key_r] = 1'b0;
  end
  assign io.filas_raw = rows;

  int kv_count = 0;
  always @(posedge clk) if (dut.key_valid) kv_count <= kv_count + 1;

  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Decimal reference model: 0 = ENTER_A, 1 = ENTER_B, 2 = SHOW_RES
  int m_st = 0, m_opa = 0, m_opb = 0, m_res = 0;
  bit m_ovf = 0;

  typedef struct { logic [27:0] segs; logic [3:0] led; } exp_t;
  exp_t sb[$];

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [27:0] exp_segs(input int v);
    logic [27:0] s;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      s[i*7 +: 7] = (i > 0 && v < p) ? 7'h7F : seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return s;
  endfunction

  task automatic push_expected();
    exp_t e;
    int v;
    v = (m_st == 0) ? m_opa : (m_st == 1) ? m_opb : m_res;
    e.segs = exp_segs(v);
    e.led  = {1'b0, m_st == 2, m_st == 1, m_ovf};
    sb.push_back(e);
  endtask

  // Key codes: 0-9 digits, 10 A(add), 11 B(CE), 12 *(AC), 13 #(EQ), 14 C, 15 D
  task automatic model_key(input int k);
    int s;
    s = m_opa + m_opb;
    if (k <= 9) begin
      if (m_st == 2) begin m_opa = k; m_opb = 0; m_ovf = 0; m_st = 0; end
      else if (m_st == 0) begin if (m_opa < 1000) m_opa = m_opa * 10 + k; end
      else begin if (m_opb < 1000) m_opb = m_opb * 10 + k; end
    end else if (k == 10) begin
      if (m_st == 0) begin m_opb = 0; m_st = 1; end
      else if (m_st == 1) begin
        if (s >= 10000) m_ovf = 1;
        m_opa = s % 10000; m_opb = 0;
      end else begin m_opa = m_res; m_opb = 0; m_st = 1; end
    end else if (k == 11) begin
      if (m_st == 0) m_opa = 0; else if (m_st == 1) m_opb = 0; else m_res = 0;
    end else if (k == 12) begin
      m_opa = 0; m_opb = 0; m_res = 0; m_ovf = 0; m_st = 0;
    end else if (k == 13) begin
      if (m_st == 1) begin
        if (s >= 10000) m_ovf = 1;
        m_res = s % 10000; m_st = 2;
      end
    end
    push_expected();
  endtask

  function automatic int kpos(input int k);
    case (k)
      1: return 0;   2: return 1;   3: return 2;   10: return 3;
      4: return 4;   5: return 5;   6: return 6;   11: return 7;
      7: return 8;   8: return 9;   9: return 10;  14: return 11;
      12: return 12; 0: return 13;  13: return 14; default: return 15;
    endcase
  endfunction

  task automatic capture(output logic [27:0] segs);
    logic [3:0] want;
    int n;
    segs = '1;
    for (int i = 0; i < 4; i++) begin
      want = ~(4'b0001 << i);
      n = 0;
      while (io.a !== want && n < 64) begin @(negedge clk); n++; end
      if (n >= 64) check("digit_enable_timeout", 32'(io.a), 32'(want));
      segs[i*7 +: 7] = io.d;
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    logic [27:0] s;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    capture(s);
    check({tag, "_seg"}, 32'(s), 32'(e.segs));
    check({tag, "_led"}, 32'(io.led), 32'(e.led));
  endtask

  task automatic press(input int k);
    int kv0, n;
    model_key(k);
    key_r = kpos(k) / 4;
    key_c = kpos(k) % 4;
    kv0 = kv_count;
    key_down = 1'b1;
    n = 0;
    while (kv_count == kv0 && n < 300) begin @(negedge clk); n++; end
    check($sformatf("key%0d_event", k), 32'(kv_count - kv0), 1);
    repeat (2) @(negedge clk);
    check($sformatf("key%0d_held_led", k), 32'(io.led[3]), 1);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    pop_compare($sformatf("key%0d", k));
  endtask

  task automatic press_seq(input int ks[$]);
    foreach (ks[i]) press(ks[i]);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int kv0, n;
    logic [3:0] cexp;

    // 1: reset values and column rotation
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_columnas", 32'(io.columnas), 32'h0E);
    check("rst_a", 32'(io.a), 32'h0E);
    check("rst_d", 32'(io.d), 32'h40);
    check("rst_led", 32'(io.led), 32'h0);
    for (int j = 1; j <= 4; j++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      cexp = ~(4'b0001 << (j % 4));
      check($sformatf("col_rotate_%0d", j), 32'(io.columnas), 32'(cexp));
    end

    // 2: 12 + 34 = 46
    press_seq('{1, 2, 10, 3, 4, 13});
    // 3: 9999 + 1 overflows to 0000, * clears the flag
    press_seq('{9, 9, 9, 9, 10, 1, 13, 12});

    // 4: bouncing key yields exactly one event
    model_key(7);
    key_r = 2; key_c = 0;
    kv0 = kv_count;
    for (int b = 0; b < 3; b++) begin
      key_down = 1'b1; repeat (2) @(negedge clk);
      key_down = 1'b0; repeat (2) @(negedge clk);
    end
    key_down = 1'b1;
    repeat (500) @(negedge clk);
    check("bounce_events", 32'(kv_count - kv0), 1);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    pop_compare("bounce");

    // CE in ENTER_A, then 5: full operand drops extra digit; chained add
    press_seq('{11, 12, 1, 2, 3, 4, 5, 10, 1, 10, 1, 13});
    // CE in SHOW_RES, ignored C, A from result, add 5
    press_seq('{11, 14, 10, 5, 13});

    // 6: reset during debounce
    press(12);
    key_r = 0; key_c = 2;
    n = 0;
    while (io.columnas !== 4'b0111 && n < 64) begin @(negedge clk); n++; end
    n = 0;
    while (io.columnas !== 4'b1011 && n < 64) begin @(negedge clk); n++; end
    check("mid_reset_col_align", 32'(io.columnas), 32'h0B);
    kv0 = kv_count;
    key_down = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    key_down = 1'b0;
    reset = 1'b0;
    check("mid_reset_columnas", 32'(io.columnas), 32'h0E);
    m_opa = 0; m_opb = 0; m_res = 0; m_ovf = 0; m_st = 0;
    push_expected();
    repeat (30) @(negedge clk);
    check("mid_reset_no_event", 32'(kv_count - kv0), 0);
    pop_compare("mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
